dmem_ahb_arbiter: RTL and testbench
===================================

# dmem_ahb_arbiter

Two-master AHB-lite arbiter that shares the single data-memory slave (the 1k-word SRAM behind `data_mem_ahb`) between the core data port (M0) and a DMA/debug port (M1). It grants one master at a time with round-robin fairness and holds the grant until the slave signals completion. It enforces a one-cycle release gap between transfers so the slave's access sequencer restarts cleanly. A watchdog ends any transfer that stalls past a configured limit with an error response.

## Interface
- `DATA_WIDTH`, 32, data bus width.
- `TIMEOUT`, 15, maximum cycles in ACCESS before a forced error response; 0 disables the watchdog.
- `hclk_i` in 1: clock, all state on rising edge.
- `hreset_i` in 1: asynchronous, active-low reset.
- `m0_hsel_i`, `m1_hsel_i` in 1: master request; held high until that master sees `hready_o`.
- `m0_haddr_i`, `m1_haddr_i` in 32: address, stable while request is high.
- `m0_hwrite_i`, `m1_hwrite_i` in 1: 1 = write.
- `m0_hwdata_i`, `m1_hwdata_i` in DATA_WIDTH: write data.
- `m0_hrdata_o`, `m1_hrdata_o` out DATA_WIDTH: read data, valid while `hready_o` = 1.
- `m0_hready_o`, `m1_hready_o` out 1: one-cycle completion pulse.
- `m0_hresp_o`, `m1_hresp_o` out 1: 1 = error (timeout), coincident with `hready_o`.
- `s_hsel_o` out 1, `s_haddr_o` out 32, `s_hwrite_o` out 1, `s_hwdata_o` out DATA_WIDTH: slave request.
- `s_hrdata_i` in DATA_WIDTH, `s_hready_i` in 1, `s_hresp_i` in 1: slave response.
- `grant_o` out 2: one-hot current owner ({M1,M0}); 00 when idle.

## Operation
- FSM states: IDLE, ACCESS, RELEASE.
- IDLE:
  - `s_hsel_o` = 0.
  - If any `mX_hsel_i` = 1, pick the winner, latch `owner`, clear the counter, and go to ACCESS.
- Winner selection:
  - A single requester wins.
  - If both request, the master not equal to `last_owner` wins.
  - `last_owner` resets to M1, so M0 wins the first tie.
- ACCESS:
  - `s_hsel_o` = 1.
  - `s_haddr_o`, `s_hwrite_o` and `s_hwdata_o` are combinationally muxed from the owner.
  - The owner's `hrdata_o` passes `s_hrdata_i` through.
  - On `s_hready_i` = 1: owner `hready_o` = 1, owner `hresp_o` = `s_hresp_i`, go to RELEASE.
  - Otherwise the counter increments.
  - If `TIMEOUT` ≠ 0 and the counter = `TIMEOUT`-1 with no ready: owner `hready_o` = 1, `hresp_o` = 1, `hrdata_o` = 0, go to RELEASE.
- RELEASE:
  - `s_hsel_o` = 0 for exactly one cycle.
  - `last_owner` ← `owner`, then go to IDLE.
- Non-owner outputs: `hready_o` = 0, `hresp_o` = 0, `hrdata_o` = 0 at all times.
- Slave outputs (`s_haddr_o`, `s_hwrite_o`, `s_hwdata_o`) are driven to 0 in IDLE and RELEASE.
- If the owner drops `hsel_i` during ACCESS (protocol violation), the transfer still runs to completion or timeout and the ready pulse is still issued.
- Requests arriving in ACCESS or RELEASE wait; a request held continuously is never dropped.
- Counter width is `$clog2(TIMEOUT+1)` (minimum 1); it saturates and never wraps.

## Timing
- Reset values:
  - All outputs 0, `grant_o` = 00.
  - State IDLE, `owner` = M0, `last_owner` = M1, counter 0.
- Reset asserted mid-ACCESS aborts immediately: `s_hsel_o` falls asynchronously and no ready pulse is issued.
- Request seen in IDLE at edge N: ACCESS from cycle N+1, with `s_hsel_o` high in cycle N+1.
- Slave ready after L cycles in ACCESS: master `hready_o` is high in the same cycle as `s_hready_i` (zero added latency on the response).
- Occupancy per transfer is 1 + L + 1 cycles (arbitration, access, release).
- Back-to-back requests from alternating masters see an owner change every transfer; the minimum gap between `s_hsel_o` pulses is 2 cycles (RELEASE + IDLE).
- A ready arriving in the same cycle as the timeout takes precedence: normal completion, `hresp_o` = `s_hresp_i`.

## Structure
- Package `dmem_arb_pkg`:
  - `arb_state_t` enum {IDLE, ACCESS, RELEASE}.
  - `master_t` (1 bit) with constants `M_CORE` = 0, `M_DMA` = 1.
- Sub-module `rr_pick2` is combinational: inputs req[1:0] and last_owner; outputs winner and valid.
- FSM, counter and muxes live in the top level.

## Test plan
- M0 read of 0x0000_0040 alone, slave ready after L=3 with data 0xDEADBEEF:
  - `s_hsel_o` is high for cycles 1–3.
  - `m0_hready_o` pulses in cycle 3 with `m0_hrdata_o` = 0xDEADBEEF.
  - `s_hsel_o` is low in cycle 4.
- Both masters request in the same cycle from reset:
  - M0 is served first, then M1.
  - Both held continuously: grants alternate M0, M1, M0, M1 over 4 transfers.
  - M1 writes 0x12345678 to 0x100, and `s_hwdata_o` shows it only while `grant_o` = 10.
- Slave never readies, TIMEOUT=15:
  - `m0_hready_o` = 1 and `m0_hresp_o` = 1 exactly in ACCESS cycle 15.
  - RELEASE follows; M1's pending request is then granted.
- Ready and timeout in the same cycle (L=15): `hresp_o` = 0 and the data is forwarded.
- `hreset_i` driven low mid-ACCESS:
  - All outputs are 0 asynchronously.
  - After release, M0 wins a tie with M1.
- M0 drops `hsel_i` mid-ACCESS: `s_hsel_o` stays high until slave ready, and `m0_hready_o` still pulses once.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-master data-memory AHB-lite arbiter.
package dmem_arb_pkg;

   // Arbiter sequencing: pick an owner, run its transfer, then force one idle cycle.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   // Master identifier; doubles as the index into the request vector.
   typedef logic master_t;
   localparam master_t M_CORE = 1'b0;
   localparam master_t M_DMA  = 1'b1;

   // Width of the stall counter: holds 0..timeout, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/dmem_ahb_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// master that did not own the previous transfer.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  master_t    last_owner_i,
   output master_t    winner_o,
   output logic       valid_o
);

   // Resolve the winner from the current request pair and the previous owner.
   always_comb begin
      valid_o  = |req_i;
      winner_o = M_CORE;
      unique case (req_i)
         2'b01:   winner_o = M_CORE;
         2'b10:   winner_o = M_DMA;
         2'b11:   winner_o = ~last_owner_i;
         default: winner_o = M_CORE;
      endcase
   end

endmodule

// File: rtl/dmem_ahb_arbiter.sv
// Shares the data-memory AHB-lite slave between the core (M0) and DMA/debug
// (M1) ports. One owner at a time, round-robin on ties, a one-cycle release
// gap after every transfer and a watchdog that errors out stalled transfers.
module dmem_ahb_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  hclk_i,
   input  logic                  hreset_i,
   // M0: core data port
   input  logic                  m0_hsel_i,
   input  logic [31:0]           m0_haddr_i,
   input  logic                  m0_hwrite_i,
   input  logic [DATA_WIDTH-1:0] m0_hwdata_i,
   output logic [DATA_WIDTH-1:0] m0_hrdata_o,
   output logic                  m0_hready_o,
   output logic                  m0_hresp_o,
   // M1: DMA / debug port
   input  logic                  m1_hsel_i,
   input  logic [31:0]           m1_haddr_i,
   input  logic                  m1_hwrite_i,
   input  logic [DATA_WIDTH-1:0] m1_hwdata_i,
   output logic [DATA_WIDTH-1:0] m1_hrdata_o,
   output logic                  m1_hready_o,
   output logic                  m1_hresp_o,
   // Slave side
   output logic                  s_hsel_o,
   output logic [31:0]           s_haddr_o,
   output logic                  s_hwrite_o,
   output logic [DATA_WIDTH-1:0] s_hwdata_o,
   input  logic [DATA_WIDTH-1:0] s_hrdata_i,
   input  logic                  s_hready_i,
   input  logic                  s_hresp_i,
   // Current owner, one-hot {M1,M0}
   output logic [1:0]            grant_o
);

   localparam int unsigned   CW      = cnt_width(TIMEOUT);
   localparam bit            WDOG_EN = (TIMEOUT != 0);
   localparam int unsigned   LIM_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] CNT_LIM = CW'(LIM_INT);
   localparam logic [CW-1:0] CNT_MAX = '1;

   arb_state_t    state_q, state_d;
   master_t       owner_q, owner_d;
   master_t       last_owner_q, last_owner_d;
   logic [CW-1:0] cnt_q, cnt_d;

   master_t                pick_winner;
   logic                   pick_valid;
   logic                   timeout_hit;
   logic                   xfer_done;
   logic                   resp_sel;
   logic [DATA_WIDTH-1:0]  rdata_sel;

   rr_pick2 u_pick (
      .req_i        ({m1_hsel_i, m0_hsel_i}),
      .last_owner_i (last_owner_q),
      .winner_o     (pick_winner),
      .valid_o      (pick_valid)
   );

   // A slave ready in the timeout cycle wins, so the watchdog only fires without one.
   assign timeout_hit = WDOG_EN && (state_q == ACCESS) && (cnt_q == CNT_LIM) && !s_hready_i;
   assign xfer_done   = (state_q == ACCESS) && (s_hready_i || timeout_hit);
   assign resp_sel    = timeout_hit ? 1'b1 : (s_hready_i & s_hresp_i);
   assign rdata_sel   = timeout_hit ? '0 : s_hrdata_i;

   // State, owner, fairness history and stall counter registers.
   always_ff @(posedge hclk_i or negedge hreset_i) begin
      if (!hreset_i) begin
         state_q      <= IDLE;
         owner_q      <= M_CORE;
         last_owner_q <= M_DMA;
         cnt_q        <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
      end
   end

   // Next-state logic plus the owner-steered request and response muxes.
   always_comb begin
      // NOTE: every output and next-state term gets a default first so no path infers a latch.
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      s_hsel_o     = 1'b0;
      s_haddr_o    = '0;
      s_hwrite_o   = 1'b0;
      s_hwdata_o   = '0;
      grant_o      = 2'b00;
      m0_hready_o  = 1'b0;
      m0_hresp_o   = 1'b0;
      m0_hrdata_o  = '0;
      m1_hready_o  = 1'b0;
      m1_hresp_o   = 1'b0;
      m1_hrdata_o  = '0;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d = pick_winner;
               cnt_d   = '0;
               state_d = ACCESS;
            end
         end

         ACCESS: begin
            s_hsel_o = 1'b1;
            if (owner_q == M_DMA) begin
               s_haddr_o   = m1_haddr_i;
               s_hwrite_o  = m1_hwrite_i;
               s_hwdata_o  = m1_hwdata_i;
               grant_o     = 2'b10;
               m1_hready_o = xfer_done;
               m1_hresp_o  = resp_sel;
               m1_hrdata_o = rdata_sel;
            end else begin
               s_haddr_o   = m0_haddr_i;
               s_hwrite_o  = m0_hwrite_i;
               s_hwdata_o  = m0_hwdata_i;
               grant_o     = 2'b01;
               m0_hready_o = xfer_done;
               m0_hresp_o  = resp_sel;
               m0_hrdata_o = rdata_sel;
            end
            if (xfer_done) begin
               state_d = RELEASE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         RELEASE: begin
            last_owner_d = owner_q;
            state_d      = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_ahb_arbiter.sv
// Directed bench for dmem_ahb_arbiter: a per-cycle vector table for the
// single-master and alternating-grant flows, then hand-written sequences for
// watchdog, ready/timeout race, mid-transfer reset and dropped request.
module tb_dmem_ahb_arbiter;

   localparam int          DW       = 32;
   localparam logic [31:0] M0_ADDR  = 32'h0000_0040;
   localparam logic [31:0] M0_WDATA = 32'hA5A5_0000;
   localparam logic [31:0] M1_ADDR  = 32'h0000_0100;
   localparam logic [31:0] M1_WDATA = 32'h1234_5678;

   logic          hclk_i = 1'b0;
   logic          hreset_i;
   logic          m0_hsel_i, m1_hsel_i;
   logic [31:0]   m0_haddr_i, m1_haddr_i;
   logic          m0_hwrite_i, m1_hwrite_i;
   logic [DW-1:0] m0_hwdata_i, m1_hwdata_i;
   logic [DW-1:0] m0_hrdata_o, m1_hrdata_o;
   logic          m0_hready_o, m1_hready_o;
   logic          m0_hresp_o, m1_hresp_o;
   logic          s_hsel_o;
   logic [31:0]   s_haddr_o;
   logic          s_hwrite_o;
   logic [DW-1:0] s_hwdata_o;
   logic [DW-1:0] s_hrdata_i;
   logic          s_hready_i, s_hresp_i;
   logic [1:0]    grant_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 hclk_i = ~hclk_i;

   dmem_ahb_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(15)) dut (
      .hclk_i      (hclk_i),
      .hreset_i    (hreset_i),
      .m0_hsel_i   (m0_hsel_i),
      .m0_haddr_i  (m0_haddr_i),
      .m0_hwrite_i (m0_hwrite_i),
      .m0_hwdata_i (m0_hwdata_i),
      .m0_hrdata_o (m0_hrdata_o),
      .m0_hready_o (m0_hready_o),
      .m0_hresp_o  (m0_hresp_o),
      .m1_hsel_i   (m1_hsel_i),
      .m1_haddr_i  (m1_haddr_i),
      .m1_hwrite_i (m1_hwrite_i),
      .m1_hwdata_i (m1_hwdata_i),
      .m1_hrdata_o (m1_hrdata_o),
      .m1_hready_o (m1_hready_o),
      .m1_hresp_o  (m1_hresp_o),
      .s_hsel_o    (s_hsel_o),
      .s_haddr_o   (s_haddr_o),
      .s_hwrite_o  (s_hwrite_o),
      .s_hwdata_o  (s_hwdata_o),
      .s_hrdata_i  (s_hrdata_i),
      .s_hready_i  (s_hready_i),
      .s_hresp_i   (s_hresp_i),
      .grant_o     (grant_o)
   );

   // One clock cycle of stimulus and the outputs expected during it.
   typedef struct packed {
      logic        do_rst;
      logic        m0_sel;
      logic        m1_sel;
      logic        s_rdy;
      logic        s_resp;
      logic [31:0] s_rdata;
      logic        e_shsel;
      logic [1:0]  e_grant;
      logic [31:0] e_haddr;
      logic        e_hwrite;
      logic [31:0] e_hwdata;
      logic        e_m0_rdy;
      logic        e_m0_resp;
      logic [31:0] e_m0_rdata;
      logic        e_m1_rdy;
      logic        e_m1_resp;
      logic [31:0] e_m1_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic m0, input logic m1, input logic rdy,
                         input logic resp, input logic [31:0] rd);
      m0_hsel_i  = m0;
      m1_hsel_i  = m1;
      s_hready_i = rdy;
      s_hresp_i  = resp;
      s_hrdata_i = rd;
   endtask

   task automatic step();
      @(posedge hclk_i);
      #1;
   endtask

   // Reset with idle inputs, released mid-cycle; returns just after the next edge.
   task automatic do_reset();
      hreset_i = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge hclk_i);
      hreset_i = 1'b1;
      step();
   endtask

   // Cycle where the slave is not selected: every output must be zero.
   function automatic vec_t v_off(input logic rst, input logic m0, input logic m1,
                                  input logic rdy, input logic [31:0] rd);
      vec_t v = '0;
      v.do_rst  = rst;
      v.m0_sel  = m0;
      v.m1_sel  = m1;
      v.s_rdy   = rdy;
      v.s_rdata = rd;
      return v;
   endfunction

   // Cycle in ACCESS owned by 'own' (0 = M0, 1 = M1).
   function automatic vec_t v_acc(input logic m0, input logic m1, input logic own,
                                  input logic rdy, input logic resp, input logic [31:0] rd);
      vec_t v = '0;
      v.m0_sel   = m0;
      v.m1_sel   = m1;
      v.s_rdy    = rdy;
      v.s_resp   = resp;
      v.s_rdata  = rd;
      v.e_shsel  = 1'b1;
      v.e_grant  = own ? 2'b10 : 2'b01;
      v.e_haddr  = own ? M1_ADDR : M0_ADDR;
      v.e_hwrite = own;
      v.e_hwdata = own ? M1_WDATA : M0_WDATA;
      if (own) begin
         v.e_m1_rdy   = rdy;
         v.e_m1_resp  = rdy & resp;
         v.e_m1_rdata = rd;
      end else begin
         v.e_m0_rdy   = rdy;
         v.e_m0_resp  = rdy & resp;
         v.e_m0_rdata = rd;
      end
      return v;
   endfunction

   task automatic check_vec(input int idx, input vec_t v);
      check($sformatf("v%0d_s_hsel", idx),    s_hsel_o,    v.e_shsel);
      check($sformatf("v%0d_grant", idx),     grant_o,     v.e_grant);
      check($sformatf("v%0d_s_haddr", idx),   s_haddr_o,   v.e_haddr);
      check($sformatf("v%0d_s_hwrite", idx),  s_hwrite_o,  v.e_hwrite);
      check($sformatf("v%0d_s_hwdata", idx),  s_hwdata_o,  v.e_hwdata);
      check($sformatf("v%0d_m0_hready", idx), m0_hready_o, v.e_m0_rdy);
      check($sformatf("v%0d_m0_hresp", idx),  m0_hresp_o,  v.e_m0_resp);
      check($sformatf("v%0d_m0_hrdata", idx), m0_hrdata_o, v.e_m0_rdata);
      check($sformatf("v%0d_m1_hready", idx), m1_hready_o, v.e_m1_rdy);
      check($sformatf("v%0d_m1_hresp", idx),  m1_hresp_o,  v.e_m1_resp);
      check($sformatf("v%0d_m1_hrdata", idx), m1_hrdata_o, v.e_m1_rdata);
   endtask

   initial begin
      m0_haddr_i  = M0_ADDR;
      m0_hwrite_i = 1'b0;
      m0_hwdata_i = M0_WDATA;
      m1_haddr_i  = M1_ADDR;
      m1_hwrite_i = 1'b1;
      m1_hwdata_i = M1_WDATA;

      // M0 read of 0x40 alone, slave ready after three ACCESS cycles.
      vecs.push_back(v_off(1, 1, 0, 0, 32'h0));
      vecs.push_back(v_acc(1, 0, 0, 0, 0, 32'hDEAD_BEEF));
      vecs.push_back(v_acc(1, 0, 0, 0, 0, 32'hDEAD_BEEF));
      vecs.push_back(v_acc(1, 0, 0, 1, 0, 32'hDEAD_BEEF));
      vecs.push_back(v_off(0, 0, 0, 1, 32'hDEAD_BEEF));
      // Both held from reset: grants alternate M0, M1, M0, M1.
      vecs.push_back(v_off(1, 1, 1, 0, 32'h0));
      vecs.push_back(v_acc(1, 1, 0, 1, 0, 32'h0BAD_F00D));
      vecs.push_back(v_off(0, 1, 1, 1, 32'h0BAD_F00D));
      vecs.push_back(v_off(0, 1, 1, 0, 32'h0));
      vecs.push_back(v_acc(1, 1, 1, 0, 0, 32'h1111_1111));
      vecs.push_back(v_acc(1, 1, 1, 1, 0, 32'h2222_2222));
      vecs.push_back(v_off(0, 1, 1, 0, 32'h0));
      vecs.push_back(v_off(0, 1, 1, 0, 32'h0));
      vecs.push_back(v_acc(1, 1, 0, 1, 1, 32'h3333_3333));
      vecs.push_back(v_off(0, 1, 1, 0, 32'h0));
      vecs.push_back(v_off(0, 1, 1, 0, 32'h0));
      vecs.push_back(v_acc(1, 1, 1, 1, 0, 32'h4444_4444));
      vecs.push_back(v_off(0, 0, 0, 0, 32'h0));
      vecs.push_back(v_off(0, 0, 0, 0, 32'h0));
      vecs.push_back(v_off(0, 0, 0, 0, 32'h0));

      // Reset state, with requests and a slave response already present.
      hreset_i = 1'b0;
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      #3;
      check("rst_s_hsel",   s_hsel_o,    1'b0);
      check("rst_grant",    grant_o,     2'b00);
      check("rst_s_haddr",  s_haddr_o,   32'h0);
      check("rst_s_hwdata", s_hwdata_o,  32'h0);
      check("rst_m0_ready", m0_hready_o, 1'b0);
      check("rst_m1_ready", m1_hready_o, 1'b0);
      check("rst_m0_rdata", m0_hrdata_o, 32'h0);

      foreach (vecs[i]) begin
         if (vecs[i].do_rst) do_reset();
         set_in(vecs[i].m0_sel, vecs[i].m1_sel, vecs[i].s_rdy, vecs[i].s_resp, vecs[i].s_rdata);
         @(negedge hclk_i);
         check_vec(i, vecs[i]);
         step();
      end

      // Watchdog: slave never ready; M1 requests while M0 is stalled.
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
      @(negedge hclk_i);
      check("to_idle_s_hsel", s_hsel_o, 1'b0);
      step();
      for (int k = 1; k <= 15; k++) begin
         if (k == 5) m1_hsel_i = 1'b1;
         @(negedge hclk_i);
         check($sformatf("to_s_hsel_%0d", k),    s_hsel_o,    1'b1);
         check($sformatf("to_m0_hready_%0d", k), m0_hready_o, 32'(k == 15));
         check($sformatf("to_m0_hresp_%0d", k),  m0_hresp_o,  32'(k == 15));
         if (k == 15) check("to_m0_hrdata", m0_hrdata_o, 32'h0);
         step();
      end
      m0_hsel_i = 1'b0;
      @(negedge hclk_i);
      check("to_rel_s_hsel", s_hsel_o, 1'b0);
      check("to_rel_grant",  grant_o,  2'b00);
      step();
      @(negedge hclk_i);
      check("to_idle2_grant", grant_o, 2'b00);
      step();
      s_hready_i = 1'b1;
      @(negedge hclk_i);
      check("to_m1_grant",  grant_o,     2'b10);
      check("to_m1_haddr",  s_haddr_o,   M1_ADDR);
      check("to_m1_hready", m1_hready_o, 1'b1);
      check("to_m1_hresp",  m1_hresp_o,  1'b0);
      step();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step();

      // Ready arrives in the same cycle the watchdog would fire.
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
      step();
      for (int k = 1; k <= 15; k++) begin
         if (k == 15) s_hready_i = 1'b1;
         @(negedge hclk_i);
         if (k == 15) begin
            check("race_m0_hready", m0_hready_o, 1'b1);
            check("race_m0_hresp",  m0_hresp_o,  1'b1);
            check("race_m0_hrdata", m0_hrdata_o, 32'hCAFE_F00D);
         end
         step();
      end
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge hclk_i);
      check("race_rel_s_hsel", s_hsel_o, 1'b0);
      step();

      // Same race with a clean slave response: hresp follows the slave, not the watchdog.
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h5A5A_A5A5);
      step();
      for (int k = 1; k <= 15; k++) begin
         if (k == 15) s_hready_i = 1'b1;
         @(negedge hclk_i);
         if (k == 15) begin
            check("race0_m0_hresp",  m0_hresp_o,  1'b0);
            check("race0_m0_hrdata", m0_hrdata_o, 32'h5A5A_A5A5);
         end
         step();
      end
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step();

      // Reset mid-ACCESS aborts at once; afterwards M0 wins the tie again.
      do_reset();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h5555_5555);
      step();
      @(negedge hclk_i);
      check("ar_pre_grant", grant_o, 2'b01);
      hreset_i   = 1'b0;
      s_hready_i = 1'b1;
      #1;
      check("ar_s_hsel",    s_hsel_o,    1'b0);
      check("ar_grant",     grant_o,     2'b00);
      check("ar_s_haddr",   s_haddr_o,   32'h0);
      check("ar_m0_hready", m0_hready_o, 1'b0);
      check("ar_m0_hrdata", m0_hrdata_o, 32'h0);
      step();
      check("ar_hold_s_hsel", s_hsel_o, 1'b0);
      s_hready_i = 1'b0;
      @(negedge hclk_i);
      hreset_i = 1'b1;
      step();
      @(negedge hclk_i);
      check("ar_tie_grant", grant_o, 2'b01);
      s_hready_i = 1'b1;
      step();
      m0_hsel_i  = 1'b0;
      s_hready_i = 1'b0;
      step();
      step();
      @(negedge hclk_i);
      check("ar_next_grant", grant_o, 2'b10);
      s_hready_i = 1'b1;
      step();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step();

      // M0 drops its request mid-ACCESS: the transfer still completes once.
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h7777_7777);
      step();
      m0_hsel_i = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         if (k == 3) s_hready_i = 1'b1;
         @(negedge hclk_i);
         check($sformatf("drop_s_hsel_%0d", k),    s_hsel_o,    1'b1);
         check($sformatf("drop_m0_hready_%0d", k), m0_hready_o, 32'(k == 3));
         step();
      end
      s_hready_i = 1'b0;
      @(negedge hclk_i);
      check("drop_rel_s_hsel",    s_hsel_o,    1'b0);
      check("drop_rel_m0_hready", m0_hready_o, 1'b0);
      step();
      @(negedge hclk_i);
      check("drop_idle_s_hsel", s_hsel_o, 1'b0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
